blend_rmw_ctrl: RTL and testbench

BLEND_RMW_CTRL -- requirements
Module: blend_rmw_ctrl

---
 rtl/blend_rmw_pkg.sv | 15 +
 rtl/blend_rmw_fifo.sv | 84 ++++++++
 rtl/blend_rmw_ctrl.sv | 144 ++++++++++++++
 tb/tb_blend_rmw_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blend_rmw_pkg.sv
// Shared defaults and the pending-fragment entry layout for the blend
// read-modify-write controller.
package blend_rmw_pkg;

  localparam int DEF_PIXEL_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH    = 24;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_BLEND_LATENCY = 3;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]  addr;
    logic [DEF_PIXEL_WIDTH-1:0] color;
  } frag_entry_t;

endpackage

// File: rtl/blend_rmw_fifo.sv
// Pending-fragment queue: holds {addr, color} between read issue and blend,
// and exposes per-slot valid/address so the top can detect address hazards.
module blend_rmw_fifo
  import blend_rmw_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int DEPTH       = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [ADDR_WIDTH-1:0]       push_addr,
  input  logic [PIXEL_WIDTH-1:0]      push_color,
  output logic                        full,
  output logic                        empty,
  output logic [ADDR_WIDTH-1:0]       head_addr,
  output logic [PIXEL_WIDTH-1:0]      head_color,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [DEPTH*ADDR_WIDTH-1:0] entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [PTR_W:0]         count_r;
  logic [DEPTH-1:0]       valid_r;
  logic [ADDR_WIDTH-1:0]  addr_mem_r  [DEPTH];
  logic [PIXEL_WIDTH-1:0] color_mem_r [DEPTH];
  logic                   push_ok_s;
  logic                   pop_ok_s;

  assign full       = (count_r == FULL_CNT);
  assign empty      = (count_r == {(PTR_W+1){1'b0}});
  assign push_ok_s  = push && !full;
  assign pop_ok_s   = pop && !empty;
  assign head_addr  = addr_mem_r[rd_ptr_r];
  assign head_color = color_mem_r[rd_ptr_r];
  assign entry_valid = valid_r;

  // Pointer, occupancy and slot-valid bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      valid_r  <= {DEPTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r          <= wr_ptr_r + 1'b1;
        valid_r[wr_ptr_r] <= 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r          <= rd_ptr_r + 1'b1;
        valid_r[rd_ptr_r] <= 1'b0;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are qualified by valid_r so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      addr_mem_r[wr_ptr_r]  <= push_addr;
      color_mem_r[wr_ptr_r] <= push_color;
    end
  end

  // Flatten slot addresses for the hazard comparators.
  always_comb begin
    entry_addr = {(DEPTH*ADDR_WIDTH){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_mem_r[i];
    end
  end

endmodule

// File: rtl/blend_rmw_ctrl.sv
// Framebuffer blend read-modify-write controller: issues dest reads, pairs
// returned data with queued source colour, tracks the blender, writes results.
module blend_rmw_ctrl
  import blend_rmw_pkg::*;
#(
  parameter int PIXEL_WIDTH   = DEF_PIXEL_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int BLEND_LATENCY = DEF_BLEND_LATENCY
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   s_frag_valid,
  output logic                   s_frag_ready,
  input  logic [ADDR_WIDTH-1:0]  s_frag_addr,
  input  logic [PIXEL_WIDTH-1:0] s_frag_color,
  output logic                   m_rd_valid,
  input  logic                   m_rd_ready,
  output logic [ADDR_WIDTH-1:0]  m_rd_addr,
  input  logic                   s_rdata_valid,
  output logic                   s_rdata_ready,
  input  logic [PIXEL_WIDTH-1:0] s_rdata,
  output logic                   blend_ce,
  output logic [PIXEL_WIDTH-1:0] blend_src,
  output logic [PIXEL_WIDTH-1:0] blend_dst,
  input  logic [PIXEL_WIDTH-1:0] blend_color,
  output logic                   m_wr_valid,
  input  logic                   m_wr_ready,
  output logic [ADDR_WIDTH-1:0]  m_wr_addr,
  output logic [PIXEL_WIDTH-1:0] m_wr_data
);

  logic                             fifo_full_s;
  logic                             fifo_empty_s;
  logic [ADDR_WIDTH-1:0]            head_addr_s;
  logic [PIXEL_WIDTH-1:0]           head_color_s;
  logic [FIFO_DEPTH-1:0]            entry_valid_s;
  logic [FIFO_DEPTH*ADDR_WIDTH-1:0] entry_addr_s;
  logic                             hazard_s;
  logic                             ce_s;
  logic                             frag_hs_s;
  logic                             rdata_hs_s;
  logic [BLEND_LATENCY-1:0]         pipe_valid_r;
  logic [ADDR_WIDTH-1:0]            pipe_addr_r [BLEND_LATENCY];

  blend_rmw_fifo #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .DEPTH       (FIFO_DEPTH)
  ) u_fifo (
    .clk         (aclk),
    .rst         (reset),
    .push        (frag_hs_s),
    .pop         (rdata_hs_s),
    .push_addr   (s_frag_addr),
    .push_color  (s_frag_color),
    .full        (fifo_full_s),
    .empty       (fifo_empty_s),
    .head_addr   (head_addr_s),
    .head_color  (head_color_s),
    .entry_valid (entry_valid_s),
    .entry_addr  (entry_addr_s)
  );

  // Same-address fragment must wait until every older copy has been written.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      hazard_s = hazard_s | (entry_valid_s[i] &&
                 (entry_addr_s[i*ADDR_WIDTH +: ADDR_WIDTH] == s_frag_addr));
    end
    for (int i = 0; i < BLEND_LATENCY; i++) begin
      hazard_s = hazard_s | (pipe_valid_r[i] && (pipe_addr_r[i] == s_frag_addr));
    end
    hazard_s = hazard_s | (m_wr_valid && (m_wr_addr == s_frag_addr));
  end

  // Handshake qualifiers are gated by reset so every output reads zero at once.
  assign ce_s          = !reset && (!m_wr_valid || m_wr_ready);
  assign blend_ce      = ce_s;
  assign s_rdata_ready = ce_s && !fifo_empty_s;
  assign rdata_hs_s    = s_rdata_valid && s_rdata_ready;
  assign s_frag_ready  = !reset && !fifo_full_s && (!m_rd_valid || m_rd_ready) && !hazard_s;
  assign frag_hs_s     = s_frag_valid && s_frag_ready;

  // Blender operands are only driven during an rdata handshake.
  always_comb begin
    if (rdata_hs_s) begin
      blend_src = head_color_s;
      blend_dst = s_rdata;
    end else begin
      blend_src = {PIXEL_WIDTH{1'b0}};
      blend_dst = {PIXEL_WIDTH{1'b0}};
    end
  end

  // Read request register: held until accepted, reloaded by each new fragment.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      m_rd_valid <= 1'b0;
      m_rd_addr  <= {ADDR_WIDTH{1'b0}};
    end else if (frag_hs_s) begin
      m_rd_valid <= 1'b1;
      m_rd_addr  <= s_frag_addr;
    end else if (m_rd_ready) begin
      m_rd_valid <= 1'b0;
    end
  end

  // Shadow of the external blender: valid/address advance only on blend_ce.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      pipe_valid_r <= {BLEND_LATENCY{1'b0}};
      for (int i = 0; i < BLEND_LATENCY; i++) begin
        pipe_addr_r[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (ce_s) begin
      pipe_valid_r[0] <= rdata_hs_s;
      pipe_addr_r[0]  <= head_addr_s;
      for (int i = 1; i < BLEND_LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_addr_r[i]  <= pipe_addr_r[i-1];
      end
    end
  end

  // Write register captures the blender result as the tail leaves the shadow.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      m_wr_valid <= 1'b0;
      m_wr_addr  <= {ADDR_WIDTH{1'b0}};
      m_wr_data  <= {PIXEL_WIDTH{1'b0}};
    end else if (ce_s) begin
      if (pipe_valid_r[BLEND_LATENCY-1]) begin
        m_wr_valid <= 1'b1;
        m_wr_addr  <= pipe_addr_r[BLEND_LATENCY-1];
        m_wr_data  <= blend_color;
      end else begin
        m_wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blend_rmw_ctrl.sv
// Scoreboard bench for blend_rmw_ctrl: an abstract RMW framebuffer model
// predicts every write; an adder stub stands in for the blender.
module tb_blend_rmw_ctrl;

  logic        aclk = 1'b0;
  logic        reset;
  logic        s_frag_valid, s_frag_ready;
  logic [23:0] s_frag_addr;
  logic [31:0] s_frag_color;
  logic        m_rd_valid, m_rd_ready;
  logic [23:0] m_rd_addr;
  logic        s_rdata_valid, s_rdata_ready;
  logic [31:0] s_rdata;
  logic        blend_ce;
  logic [31:0] blend_src, blend_dst, blend_color;
  logic        m_wr_valid, m_wr_ready;
  logic [23:0] m_wr_addr;
  logic [31:0] m_wr_data;

  blend_rmw_ctrl dut (
    .aclk(aclk), .reset(reset),
    .s_frag_valid(s_frag_valid), .s_frag_ready(s_frag_ready),
    .s_frag_addr(s_frag_addr), .s_frag_color(s_frag_color),
    .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_addr(m_rd_addr),
    .s_rdata_valid(s_rdata_valid), .s_rdata_ready(s_rdata_ready), .s_rdata(s_rdata),
    .blend_ce(blend_ce), .blend_src(blend_src), .blend_dst(blend_dst),
    .blend_color(blend_color),
    .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_mode, rsp_mode, wr_mode;   // 0 = low, 1 = high, 2 = random
  logic junk_rdata;
  logic [31:0] fb_mem [256];        // framebuffer as seen by the memory
  logic [31:0] model_fb [256];      // framebuffer as predicted in acceptance order
  logic [55:0] exp_q [$];
  logic [7:0]  rd_q [$];
  int wr_cnt = 0, acc_cnt = 0;
  int last_acc_cyc, last_rdata_cyc, first_rdata_cyc, wr_rise_cyc, last20;
  logic rdata_mark = 1'b0;
  logic prev_wr = 1'b0;
  logic [23:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic [31:0] bp [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Blender stub: three ce-qualified stages computing src + dst.
  always @(posedge aclk or posedge reset) begin
    if (reset) begin
      bp[0] <= 32'h0; bp[1] <= 32'h0; bp[2] <= 32'h0;
    end else if (blend_ce) begin
      bp[0] <= blend_src + blend_dst;
      bp[1] <= bp[0];
      bp[2] <= bp[1];
    end
  end
  assign blend_color = bp[2];

  // Ready/rdata drivers, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge aclk); #2;
      m_rd_ready = (rd_mode == 2) ? ($urandom_range(0, 1) == 1) : (rd_mode == 1);
      m_wr_ready = (wr_mode == 2) ? ($urandom_range(0, 3) != 0) : (wr_mode == 1);
      if (reset) begin
        s_rdata_valid = 1'b0;
      end else if (junk_rdata) begin
        s_rdata_valid = 1'b1;
        s_rdata = $urandom;
      end else if (rd_q.size() > 0 && (rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(0, 2) != 0))) begin
        s_rdata_valid = 1'b1;
        s_rdata = fb_mem[rd_q[0]];
      end else begin
        s_rdata_valid = 1'b0;
      end
    end
  end

  // Monitors: read traffic, fragment acceptance (model update), writes (compare).
  initial begin
    forever begin
      @(negedge aclk);
      if (!reset) begin
        if (s_rdata_valid && s_rdata_ready && rd_q.size() > 0) begin
          void'(rd_q.pop_front());
          last_rdata_cyc = cyc;
          if (rdata_mark) begin first_rdata_cyc = cyc; rdata_mark = 1'b0; end
        end
        if (m_rd_valid && m_rd_ready) rd_q.push_back(m_rd_addr[7:0]);
        if (s_frag_valid && s_frag_ready) begin
          logic [31:0] e;
          e = s_frag_color + model_fb[s_frag_addr[7:0]];
          model_fb[s_frag_addr[7:0]] = e;
          exp_q.push_back({s_frag_addr, e});
          acc_cnt++;
          last_acc_cyc = cyc;
        end
        if (m_wr_valid && !prev_wr) wr_rise_cyc = cyc;
        if (m_wr_valid && m_wr_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {40'h0, m_wr_addr}, 64'hFFFF_FFFF);
          end else begin
            logic [55:0] x;
            x = exp_q.pop_front();
            chk("wr_addr", {40'h0, m_wr_addr}, {40'h0, x[55:32]});
            chk("wr_data", {32'h0, m_wr_data}, {32'h0, x[31:0]});
          end
          fb_mem[m_wr_addr[7:0]] = m_wr_data;
          wr_cnt++;
          last_wr_addr = m_wr_addr;
          last_wr_data = m_wr_data;
          if (m_wr_addr == 24'h20) last20 = cyc;
        end
      end
      prev_wr = m_wr_valid;
    end
  end

  task automatic send_frag(input logic [23:0] a, input logic [31:0] c, output int waited);
    s_frag_valid = 1'b1; s_frag_addr = a; s_frag_color = c;
    waited = 0;
    forever begin
      @(negedge aclk);
      if (s_frag_ready) break;
      waited++;
      if (waited > 300) begin
        chk("accept_timeout", 64'h0, 64'h1);
        break;
      end
    end
    @(posedge aclk); #1;
  endtask

  task automatic frag_idle();
    s_frag_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_wr_valid) && n < budget) begin
      @(negedge aclk); n++;
    end
    chk("drain_timeout", (n >= budget), 64'h0);
    @(posedge aclk); #1;
  endtask

  function automatic logic any_output();
    return |{m_rd_valid, m_rd_addr, s_rdata_ready, blend_ce, blend_src, blend_dst,
             m_wr_valid, m_wr_addr, m_wr_data, s_frag_ready};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, bad, bad2, wc;
    reset = 1'b0; s_frag_valid = 1'b0; s_frag_addr = 24'h0; s_frag_color = 32'h0;
    s_rdata_valid = 1'b0; s_rdata = 32'h0; m_rd_ready = 1'b1; m_wr_ready = 1'b1;
    rd_mode = 1; rsp_mode = 1; wr_mode = 1; junk_rdata = 1'b0;
    for (int i = 0; i < 256; i++) fb_mem[i] = {4{i[7:0]}} ^ 32'h1357_9BDF;
    fb_mem[16] = 32'h0000_00FF;
    for (int i = 0; i < 256; i++) model_fb[i] = fb_mem[i];
    #1 reset = 1'b1;
    #1 chk("reset_outputs_zero", any_output(), 64'h0);
    repeat (3) @(posedge aclk);
    #1 reset = 1'b0;
    @(negedge aclk) chk("ready_after_reset", s_frag_ready, 64'h1);

    // rdata offered while nothing is pending must be ignored
    @(posedge aclk); #1 junk_rdata = 1'b1;
    repeat (4) begin @(negedge aclk); chk("rdata_ready_when_empty", s_rdata_ready, 64'h0); end
    @(posedge aclk); #1 junk_rdata = 1'b0;
    repeat (8) @(posedge aclk);
    #1 chk("no_write_from_junk", wr_cnt, 64'h0);

    // single fragment, latency and data
    send_frag(24'h10, 32'h80FF_0000, w);
    frag_idle();
    wait_drain(100);
    chk("single_addr", {40'h0, last_wr_addr}, 64'h10);
    chk("single_data", {32'h0, last_wr_data}, 64'h80FF_00FF);
    chk("single_latency", wr_rise_cyc - last_rdata_cyc, 64'd4);

    // FIFO full with rdata withheld
    rsp_mode = 0;
    for (int k = 0; k < 4; k++) send_frag(24'h40 + 24'(k), $urandom, w);
    s_frag_addr = 24'h44; s_frag_color = $urandom;
    bad = 0;
    repeat (3) begin @(negedge aclk); if (s_frag_ready) bad++; end
    chk("full_blocks_fifth", bad, 64'h0);
    @(posedge aclk); #1;
    first_rdata_cyc = 32'h7FFF_FFFF; rdata_mark = 1'b1; rsp_mode = 1;
    send_frag(24'h44, s_frag_color, w);
    chk("fifth_after_first_rdata", (last_acc_cyc > first_rdata_cyc) && (first_rdata_cyc != 32'h7FFF_FFFF), 64'h1);
    frag_idle();
    wait_drain(200);

    // address hazard
    last20 = -1;
    send_frag(24'h20, $urandom, w);
    send_frag(24'h21, $urandom, w);
    chk("no_hazard_0x21_wait", w, 64'h0);
    send_frag(24'h20, $urandom, w);
    chk("hazard_waits_for_write", (last20 >= 0) && (last_acc_cyc > last20), 64'h1);
    frag_idle();
    wait_drain(200);

    // write backpressure
    wr_mode = 0;
    for (int k = 0; k < 3; k++) send_frag(24'h60 + 24'(k), $urandom, w);
    frag_idle();
    bad = 0;
    while (!m_wr_valid && bad < 50) begin @(negedge aclk); bad++; end
    chk("wr_valid_reached", m_wr_valid, 64'h1);
    wc = wr_cnt; bad = 0; bad2 = 0;
    repeat (10) begin
      @(negedge aclk);
      if (blend_ce || s_rdata_ready) bad++;
      if (!m_wr_valid) bad2++;
    end
    chk("backpressure_ce_low", bad, 64'h0);
    chk("backpressure_wr_held", bad2, 64'h0);
    chk("backpressure_no_write", wr_cnt - wc, 64'h0);
    @(posedge aclk); #1 wr_mode = 1;
    wait_drain(200);
    chk("backpressure_all_written", wr_cnt - wc, 64'd3);

    // reset mid-operation
    wr_mode = 0;
    for (int k = 0; k < 3; k++) send_frag(24'h70 + 24'(k), $urandom, w);
    frag_idle();
    repeat (6) @(posedge aclk);
    #1 reset = 1'b1;
    #1 chk("midreset_outputs_zero", any_output(), 64'h0);
    exp_q.delete(); rd_q.delete();
    for (int i = 0; i < 256; i++) model_fb[i] = fb_mem[i];
    wr_mode = 1;
    repeat (2) @(posedge aclk);
    #1 reset = 1'b0;
    @(negedge aclk) chk("ready_after_midreset", s_frag_ready, 64'h1);
    wc = wr_cnt;
    repeat (20) @(negedge aclk);
    chk("no_write_after_reset", wr_cnt - wc, 64'h0);
    @(posedge aclk); #1;
    send_frag(24'h73, $urandom, w);
    frag_idle();
    wait_drain(100);
    chk("post_reset_fragment", wr_cnt - wc, 64'd1);

    // read request stall
    rd_mode = 0;
    @(posedge aclk); #1;
    send_frag(24'h50, $urandom, w);
    s_frag_addr = 24'h51; s_frag_color = $urandom;
    bad = 0; bad2 = 0;
    repeat (5) begin
      @(negedge aclk);
      if (s_frag_ready) bad++;
      if (!m_rd_valid || m_rd_addr != 24'h50) bad2++;
    end
    chk("rd_stall_ready_low", bad, 64'h0);
    chk("rd_stall_addr_stable", bad2, 64'h0);
    @(posedge aclk); #1 rd_mode = 1;
    send_frag(24'h51, s_frag_color, w);
    frag_idle();
    wait_drain(200);

    // randomized traffic with hazards and random stalls
    rd_mode = 2; rsp_mode = 2; wr_mode = 2;
    wc = wr_cnt;
    for (int n = 0; n < 150; n++) begin
      send_frag(24'($urandom_range(0, 15)), $urandom, w);
      if ($urandom_range(0, 3) == 0) begin
        frag_idle();
        repeat ($urandom_range(0, 3)) @(posedge aclk);
        #1;
      end
    end
    frag_idle();
    wait_drain(3000);
    chk("random_write_count", wr_cnt - wc, 64'd150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
